// File: rtl/spi_mem_responder.sv
// rtl/spi_mem_responder.sv - SPI mode-0 byte-addressed memory responder (read 0x03 / write 0x02)
module spi_mem_responder #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_cs,
    input  logic spi_sclk,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic spi_miso_oe,
    output logic busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_RDATA, S_WDATA, S_IGNORE
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic         r_cs_meta, r_cs_sync, r_cs_prev;
    logic         r_sclk_meta, r_sclk_sync, r_sclk_prev;
    logic         r_mosi_meta, r_mosi_sync;
    logic [1:0]   r_vld;
    logic         r_armed;
    logic [4:0]   r_cnt;
    logic [6:0]   r_shift;
    logic [AW-1:0] r_addr;
    logic         r_is_write;
    logic [2:0]   r_rbit;
    logic         r_miso;
    logic [7:0]   r_mem [DEPTH];

    logic         w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall, w_oe;
    logic [7:0]   w_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_meta   <= 1'b1;
            r_cs_sync   <= 1'b1;
            r_cs_prev   <= 1'b1;
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
            r_vld       <= 2'b00;
            r_armed     <= 1'b0;
        end else begin
            r_cs_meta   <= spi_cs;
            r_cs_sync   <= r_cs_meta;
            r_cs_prev   <= r_cs_sync;
            r_sclk_meta <= spi_sclk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_prev <= r_sclk_sync;
            r_mosi_meta <= spi_mosi;
            r_mosi_sync <= r_mosi_meta;
            r_vld       <= {r_vld[0], 1'b1};
            // Only a chip select genuinely seen high after reset can produce a falling edge
            r_armed     <= r_armed | (r_vld[1] & r_cs_sync);
        end
    end

    assign w_cs_fall   = r_armed & r_cs_prev & ~r_cs_sync;
    assign w_cs_rise   = r_cs_sync & ~r_cs_prev;
    assign w_sclk_rise = r_sclk_sync & ~r_sclk_prev & ~r_cs_sync;
    assign w_sclk_fall = ~r_sclk_sync & r_sclk_prev & ~r_cs_sync;
    assign w_byte      = {r_shift, r_mosi_sync};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_cs_fall) w_next = S_CMD;
            S_CMD:   if (w_sclk_rise && r_cnt == 5'd7)
                         w_next = (w_byte == 8'h03 || w_byte == 8'h02) ? S_ADDR : S_IGNORE;
            S_ADDR:  if (w_sclk_rise && r_cnt == 5'd23)
                         w_next = r_is_write ? S_WDATA : S_RDATA;
            default: w_next = r_state;
        endcase
        if (r_state != S_IDLE && w_cs_rise) w_next = S_IDLE;
    end

    always_comb begin
        w_oe        = (r_state == S_RDATA) & ~r_cs_sync;
        spi_miso_oe = w_oe;
        spi_miso    = w_oe & r_miso;
        busy        = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_shift    <= '0;
            r_addr     <= '0;
            r_is_write <= 1'b0;
            r_rbit     <= '0;
            r_miso     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
        end else if (r_state == S_IDLE || w_cs_rise) begin
            r_cnt      <= '0;
            r_shift    <= '0;
            r_addr     <= '0;
            r_is_write <= 1'b0;
            r_rbit     <= '0;
            r_miso     <= 1'b0;
        end else begin
            case (r_state)
                S_CMD: if (w_sclk_rise) begin
                    r_shift <= {r_shift[5:0], r_mosi_sync};
                    if (r_cnt == 5'd7) begin
                        r_cnt      <= '0;
                        r_is_write <= (w_byte == 8'h02);
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_ADDR: if (w_sclk_rise) begin
                    r_addr <= {r_addr[AW-2:0], r_mosi_sync};
                    r_cnt  <= (r_cnt == 5'd23) ? 5'd0 : r_cnt + 5'd1;
                end
                // Each byte is fetched bit by bit, so the address bump lands exactly between bytes
                S_RDATA: if (w_sclk_fall) begin
                    r_miso <= r_mem[r_addr][3'd7 - r_rbit];
                    r_rbit <= r_rbit + 3'd1;
                    if (r_rbit == 3'd7) r_addr <= r_addr + 1'b1;
                end
                S_WDATA: if (w_sclk_rise) begin
                    r_shift <= {r_shift[5:0], r_mosi_sync};
                    if (r_cnt == 5'd7) begin
                        r_mem[r_addr] <= w_byte;
                        r_addr        <= r_addr + 1'b1;
                        r_cnt         <= '0;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_responder.sv
// tb/tb_spi_mem_responder.sv - bench for spi_mem_responder: directed table, corner sequences, random vs memory model
module tb_spi_mem_responder;
    localparam int DEPTH = 64;
    localparam int H     = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic spi_cs = 1'b1;
    logic spi_sclk = 1'b0;
    logic spi_mosi = 1'b0;
    logic spi_miso, spi_miso_oe, busy;

    spi_mem_responder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .spi_cs(spi_cs), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .busy(busy)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_oe   = 1'b0;
    int   oe_bad   = 0;
    logic [7:0] ref_mem [DEPTH];

    typedef struct {
        logic        wr;
        logic [7:0]  op;
        logic [23:0] addr;
        int          n;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic m);
        @(negedge clk);
        spi_mosi = b;
        repeat (H) @(negedge clk);
        m = spi_miso;
        if (spi_miso_oe !== exp_oe) oe_bad++;
        if (spi_miso_oe !== 1'b1 && spi_miso !== 1'b0) oe_bad++;
        spi_sclk = 1'b1;
        repeat (H) @(negedge clk);
        spi_sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic m;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], m);
            rx[i] = m;
        end
    endtask

    task automatic cs_begin();
        @(negedge clk);
        spi_cs = 1'b0;
        exp_oe = 1'b0;
        oe_bad = 0;
        repeat (H) @(negedge clk);
    endtask

    task automatic cs_end(input string name);
        int k;
        repeat (H) @(negedge clk);
        spi_cs = 1'b1;
        exp_oe = 1'b0;
        k = 0;
        while (busy !== 1'b0 && k < 4) begin
            @(negedge clk);
            k++;
        end
        check({name, "_busy_release"}, {31'b0, busy}, 32'h0);
        check({name, "_oe_phase"}, oe_bad, 32'h0);
        repeat (4) @(negedge clk);
    endtask

    task automatic xact(input string name, input logic [7:0] op, input logic [23:0] addr,
                        input int n, input logic [31:0] wdata, output logic [31:0] rdata);
        logic [7:0] rx;
        rdata = '0;
        cs_begin();
        spi_byte(op, rx);
        spi_byte(addr[23:16], rx);
        spi_byte(addr[15:8], rx);
        spi_byte(addr[7:0], rx);
        exp_oe = (op == 8'h03);
        for (int i = 0; i < n; i++) begin
            spi_byte(op == 8'h02 ? wdata[31-8*i -: 8] : 8'h00, rx);
            rdata[31-8*i -: 8] = rx;
        end
        cs_end(name);
    endtask

    task automatic model_write(input logic [23:0] addr, input int n, input logic [31:0] data);
        for (int i = 0; i < n; i++) ref_mem[(int'(addr) + i) % DEPTH] = data[31-8*i -: 8];
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vt[8];
        logic [31:0] rd;
        logic [7:0]  rx;
        logic        m;

        vt[0] = '{1'b1, 8'h02, 24'h000005, 2, 32'hA53C0000, 32'h0};
        vt[1] = '{1'b0, 8'h03, 24'h000005, 2, 32'h0, 32'hA53C0000};
        vt[2] = '{1'b1, 8'h02, 24'h00003F, 2, 32'h11220000, 32'h0};
        vt[3] = '{1'b0, 8'h03, 24'h00003F, 2, 32'h0, 32'h11220000};
        vt[4] = '{1'b1, 8'h02, 24'h000002, 1, 32'h77000000, 32'h0};
        vt[5] = '{1'b0, 8'h03, 24'hFFFF02, 1, 32'h0, 32'h77000000};
        vt[6] = '{1'b0, 8'h03, 24'h000000, 3, 32'h0, 32'h22007700};
        vt[7] = '{1'b0, 8'h03, 24'h00FF04, 2, 32'h0, 32'h00A50000};

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;

        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_oe", {31'b0, spi_miso_oe}, 32'h0);
        check("reset_miso", {31'b0, spi_miso}, 32'h0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_busy", {31'b0, busy}, 32'h0);

        for (int v = 0; v < 8; v++) begin
            xact($sformatf("vec%0d", v), vt[v].op, vt[v].addr, vt[v].n, vt[v].data, rd);
            if (vt[v].wr) model_write(vt[v].addr, vt[v].n, vt[v].data);
            else for (int b = 0; b < vt[v].n; b++)
                check($sformatf("vec%0d_byte%0d", v, b), {24'b0, rd[31-8*b -: 8]}, {24'b0, vt[v].exp[31-8*b -: 8]});
        end

        // Unsupported opcode: no output drive, busy until deselect, memory untouched
        cs_begin();
        spi_byte(8'h9F, rx);
        for (int i = 0; i < 32; i++) spi_bit(1'($urandom), m);
        check("ignore_busy_held", {31'b0, busy}, 32'h1);
        cs_end("ignore");
        xact("ignore_readback", 8'h03, 24'h000005, 2, 32'h0, rd);
        check("ignore_mem_unchanged", rd[31:16], 32'hA53C);

        // Partial trailing byte is discarded
        cs_begin();
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h10, rx);
        spi_byte(8'hFF, rx);
        for (int i = 0; i < 5; i++) spi_bit(1'b0, m);
        cs_end("partial");
        model_write(24'h000010, 1, 32'hFF000000);
        xact("partial_read", 8'h03, 24'h000010, 2, 32'h0, rd);
        check("partial_byte0", {24'b0, rd[31:24]}, 32'hFF);
        check("partial_byte1", {24'b0, rd[23:16]}, 32'h00);

        // Reset during a read data phase
        cs_begin();
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h05, rx);
        exp_oe = 1'b1;
        for (int i = 0; i < 4; i++) spi_bit(1'b0, m);
        check("midread_oe_before_reset", {31'b0, spi_miso_oe}, 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midread_reset_oe", {31'b0, spi_miso_oe}, 32'h0);
        check("midread_reset_busy", {31'b0, busy}, 32'h0);
        check("midread_reset_miso", {31'b0, spi_miso}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_reset_cs_low_idle", {31'b0, busy}, 32'h0);
        spi_cs = 1'b1;
        repeat (8) @(negedge clk);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        xact("post_reset_read", 8'h03, 24'h000005, 2, 32'h0, rd);
        check("post_reset_cleared", rd[31:16], 32'h0);

        for (int t = 0; t < 24; t++) begin
            logic        wr;
            logic [23:0] a;
            int          n;
            logic [31:0] d;
            wr = 1'($urandom_range(0, 1));
            a  = 24'($urandom);
            n  = $urandom_range(1, 4);
            d  = $urandom;
            xact($sformatf("rnd%0d", t), wr ? 8'h02 : 8'h03, a, n, d, rd);
            if (wr) model_write(a, n, d);
            else for (int b = 0; b < n; b++)
                check($sformatf("rnd%0d_byte%0d", t, b), {24'b0, rd[31-8*b -: 8]},
                      {24'b0, ref_mem[(int'(a) + b) % DEPTH]});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
